// File: rtl/ddp_entry_arbiter_pkg.sv
// Shared sizing defaults and FSM encoding for the DDP ring entry arbiter.
// Pure declarations: no latency, no flow control.
package ddp_entry_arbiter_pkg;
  localparam int M_PACKET_SIZE = 38;
  localparam int ARB_OCC_W     = 6;
  localparam int ARB_RING_CAP  = 32;
  localparam int ARB_BURST_MAX = 4;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/ddp_arb_credit.sv
// Ring occupancy credits: +1 per external admission, -1 per RETIRE, sticky ERR on underflow.
// Credit freed by RETIRE becomes usable the cycle after; THROTTLE flags a blocked external request.
module ddp_arb_credit
  import ddp_entry_arbiter_pkg::*;
#(
  parameter int OCC_W    = ARB_OCC_W,
  parameter int RING_CAP = ARB_RING_CAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             grant_ex,
  input  logic             retire,
  input  logic             send_ex,
  output logic [OCC_W-1:0] occ,
  output logic             credit_ok,
  output logic             throttle,
  output logic             err
);
  localparam logic [OCC_W-1:0] CAP = OCC_W'(RING_CAP);

  assign credit_ok = (occ < CAP);
  assign throttle  = send_ex && !credit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
      err <= 1'b0;
    end else begin
      if (retire && (occ == '0)) err <= 1'b1;
      // Simultaneous admit and retire cancel; underflow clamps at zero.
      if (grant_ex && !retire) occ <= occ + OCC_W'(1);
      else if (!grant_ex && retire && (occ != '0)) occ <= occ - OCC_W'(1);
    end
  end
endmodule

// File: rtl/ddp_entry_arbiter.sv
// Ring-entry arbiter: internal-priority with burst limit, credit-throttled external, 1-cycle output register.
// Acks are combinational in the grant cycle; holds PACKET_OUT while Ack_in=0. Stats ports under DDP_ARB_STATS_EN.
module ddp_entry_arbiter
  import ddp_entry_arbiter_pkg::*;
#(
  parameter int PKT_W     = M_PACKET_SIZE,
  parameter int OCC_W     = ARB_OCC_W,
  parameter int RING_CAP  = ARB_RING_CAP,
  parameter int BURST_MAX = ARB_BURST_MAX
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             Send_in_EX,
  input  logic [PKT_W-1:0] PACKET_IN_EX,
  output logic             Ack_out_EX,
  input  logic             Send_in_IN,
  input  logic [PKT_W-1:0] PACKET_IN_IN,
  output logic             Ack_out_IN,
  output logic             Send_out,
  output logic [PKT_W-1:0] PACKET_OUT,
  input  logic             Ack_in,
  input  logic             RETIRE,
  output logic [OCC_W-1:0] OCC,
  output logic             THROTTLE,
  output logic             ERR
`ifdef DDP_ARB_STATS_EN
  ,
  output logic [15:0]      GNT_CNT_EX,
  output logic [15:0]      GNT_CNT_IN,
  output logic [15:0]      STALL_CNT
`endif
);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  arb_state_t       state, state_nxt;
  logic [PKT_W-1:0] pkt_q;
  logic [3:0]       burst;
  logic             credit_ok, ex_ok, in_ok, room, grant_ex, grant_in;

  ddp_arb_credit #(
    .OCC_W    (OCC_W),
    .RING_CAP (RING_CAP)
  ) u_credit (
    .clk       (CP),
    .rst       (MR),
    .grant_ex  (grant_ex),
    .retire    (RETIRE),
    .send_ex   (Send_in_EX),
    .occ       (OCC),
    .credit_ok (credit_ok),
    .throttle  (THROTTLE),
    .err       (ERR)
  );

  assign ex_ok = Send_in_EX && credit_ok;
  assign in_ok = Send_in_IN;
  assign room  = (state == ARB_EMPTY) || Ack_in;

  always_comb begin
    grant_ex  = 1'b0;
    grant_in  = 1'b0;
    state_nxt = state;
    // Reset gates the grants so no Ack leaks out while MR is held.
    if (room && !MR) begin
      if (ex_ok && (!in_ok || (burst == BMAX))) grant_ex = 1'b1;
      else if (in_ok)                          grant_in = 1'b1;
    end
    if (grant_ex || grant_in)                  state_nxt = ARB_FULL;
    else if ((state == ARB_FULL) && Ack_in)    state_nxt = ARB_EMPTY;
  end

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state <= ARB_EMPTY;
      pkt_q <= '0;
      burst <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ex)      pkt_q <= PACKET_IN_EX;
      else if (grant_in) pkt_q <= PACKET_IN_IN;
      // Counts internal wins only while an eligible external is kept waiting.
      if (!ex_ok || grant_ex) burst <= '0;
      else if (grant_in)      burst <= burst + 4'd1;
    end
  end

  assign Ack_out_EX = grant_ex;
  assign Ack_out_IN = grant_in;
  assign Send_out   = (state == ARB_FULL);
  assign PACKET_OUT = pkt_q;

`ifdef DDP_ARB_STATS_EN
  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      GNT_CNT_EX <= '0;
      GNT_CNT_IN <= '0;
      STALL_CNT  <= '0;
    end else begin
      if (grant_ex && (GNT_CNT_EX != 16'hFFFF)) GNT_CNT_EX <= GNT_CNT_EX + 16'd1;
      if (grant_in && (GNT_CNT_IN != 16'hFFFF)) GNT_CNT_IN <= GNT_CNT_IN + 16'd1;
      if (THROTTLE && (STALL_CNT  != 16'hFFFF)) STALL_CNT  <= STALL_CNT + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ddp_entry_arbiter.sv
// Directed scenarios plus constrained-random traffic against a behavioural model of the ring entry arbiter.
module tb_ddp_entry_arbiter;
  localparam int PKT_W     = 38;
  localparam int OCC_W     = 6;
  localparam int RING_CAP  = 32;
  localparam int BURST_MAX = 4;

  logic             CP = 1'b0;
  logic             MR = 1'b1;
  logic             Send_in_EX = 1'b0;
  logic [PKT_W-1:0] PACKET_IN_EX = '0;
  logic             Ack_out_EX;
  logic             Send_in_IN = 1'b0;
  logic [PKT_W-1:0] PACKET_IN_IN = '0;
  logic             Ack_out_IN;
  logic             Send_out;
  logic [PKT_W-1:0] PACKET_OUT;
  logic             Ack_in = 1'b0;
  logic             RETIRE = 1'b0;
  logic [OCC_W-1:0] OCC;
  logic             THROTTLE;
  logic             ERR;
`ifdef DDP_ARB_STATS_EN
  logic [15:0]      GNT_CNT_EX, GNT_CNT_IN, STALL_CNT;
`endif

  always #5 CP = ~CP;

  ddp_entry_arbiter #(
    .PKT_W(PKT_W), .OCC_W(OCC_W), .RING_CAP(RING_CAP), .BURST_MAX(BURST_MAX)
  ) dut (
    .CP(CP), .MR(MR),
    .Send_in_EX(Send_in_EX), .PACKET_IN_EX(PACKET_IN_EX), .Ack_out_EX(Ack_out_EX),
    .Send_in_IN(Send_in_IN), .PACKET_IN_IN(PACKET_IN_IN), .Ack_out_IN(Ack_out_IN),
    .Send_out(Send_out), .PACKET_OUT(PACKET_OUT), .Ack_in(Ack_in),
    .RETIRE(RETIRE), .OCC(OCC), .THROTTLE(THROTTLE), .ERR(ERR)
`ifdef DDP_ARB_STATS_EN
    , .GNT_CNT_EX(GNT_CNT_EX), .GNT_CNT_IN(GNT_CNT_IN), .STALL_CNT(STALL_CNT)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model: packets in the output slot, ring population, sticky error,
  // and how many internal wins in a row an eligible external has sat through.
  int               m_occ;
  bit               m_err;
  bit               m_full;
  logic [PKT_W-1:0] m_pkt;
  int               m_wait_wins;
  bit               lg_ex, lg_in;
  string            glog;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_occ = 0; m_err = 0; m_full = 0; m_pkt = '0; m_wait_wins = 0;
    lg_ex = 0; lg_in = 0;
  endtask

  function automatic logic [PKT_W-1:0] rand_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[PKT_W-1:0];
  endfunction

  // One clock: check everything at the falling edge, then advance the model.
  task automatic cycle();
    bit ex_ok, room, gex, gin, ret, ack;
    logic [PKT_W-1:0] pex, pin;
    @(negedge CP);
    ex_ok = Send_in_EX && (m_occ < RING_CAP);
    room  = !m_full || Ack_in;
    gex   = room && ex_ok && (!Send_in_IN || m_wait_wins >= BURST_MAX);
    gin   = room && Send_in_IN && !gex;
    check("ack_ex",   64'(Ack_out_EX), 64'(gex));
    check("ack_in",   64'(Ack_out_IN), 64'(gin));
    check("send_out", 64'(Send_out),   64'(m_full));
    check("occ",      64'(OCC),        64'(m_occ));
    check("err",      64'(ERR),        64'(m_err));
    check("throttle", 64'(THROTTLE),   64'(Send_in_EX && (m_occ >= RING_CAP)));
    if (m_full) check("pkt_out", 64'(PACKET_OUT), 64'(m_pkt));
    pex = PACKET_IN_EX; pin = PACKET_IN_IN; ret = RETIRE; ack = Ack_in;
    @(posedge CP);
    if (gex)      m_pkt = pex;
    else if (gin) m_pkt = pin;
    m_full      = gex || gin || (m_full && !ack);
    m_wait_wins = (!ex_ok || gex) ? 0 : m_wait_wins + int'(gin);
    if (ret && m_occ == 0) m_err = 1;
    m_occ = m_occ + int'(gex) - int'(ret);
    if (m_occ < 0) m_occ = 0;
    lg_ex = gex; lg_in = gin;
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic async_reset();
    #2;
    MR = 1'b1;
    #1;
    check("rst_send_out", 64'(Send_out),   64'(0));
    check("rst_occ",      64'(OCC),        64'(0));
    check("rst_err",      64'(ERR),        64'(0));
    check("rst_pkt",      64'(PACKET_OUT), 64'(0));
    check("rst_ack_ex",   64'(Ack_out_EX), 64'(0));
    check("rst_ack_in",   64'(Ack_out_IN), 64'(0));
    model_reset();
    @(posedge CP);
    #1;
    MR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge CP);
    #1;
    // Requests while reset is held must not be acknowledged.
    Send_in_EX = 1'b1; Send_in_IN = 1'b1; Ack_in = 1'b1;
    #1;
    check("hold_ack_ex",   64'(Ack_out_EX), 64'(0));
    check("hold_ack_in",   64'(Ack_out_IN), 64'(0));
    check("hold_send_out", 64'(Send_out),   64'(0));
    check("hold_occ",      64'(OCC),        64'(0));
    check("hold_err",      64'(ERR),        64'(0));
    Send_in_EX = 1'b0; Send_in_IN = 1'b0;
    MR = 1'b0;

    // Underflow: RETIRE at empty ring sets sticky ERR and leaves OCC at 0.
    RETIRE = 1'b1;
    cycle();
    RETIRE = 1'b0;
    repeat (3) cycle();
    check("err_sticky", 64'(ERR), 64'(1));
    check("err_occ",    64'(OCC), 64'(0));
    async_reset();

    // Back-to-back external packets with the M stage always ready.
    Ack_in = 1'b1; Send_in_EX = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      PACKET_IN_EX = PKT_W'(i);
      cycle();
      check("b2b_ack", 64'(lg_ex), 64'(1));
      check("b2b_pkt", 64'(PACKET_OUT), 64'(i));
    end
    Send_in_EX = 1'b0;
    cycle();
    check("b2b_occ", 64'(OCC), 64'(3));

    // Both sources saturating: four internal wins, then one external.
    Send_in_EX = 1'b1; Send_in_IN = 1'b1; Ack_in = 1'b1;
    PACKET_IN_EX = rand_pkt(); PACKET_IN_IN = rand_pkt();
    glog = "";
    for (int i = 0; i < 10; i++) begin
      cycle();
      glog = {glog, lg_ex ? "E" : (lg_in ? "I" : "-")};
      if (lg_ex) PACKET_IN_EX = rand_pkt();
      if (lg_in) PACKET_IN_IN = rand_pkt();
    end
    checks++;
    assert (glog == "IIIIEIIIIE")
    else begin
      errors++;
      $error("FAIL grant_order: observed %s expected IIIIEIIIIE", glog);
    end

    // Drain, park 0x15 in the output register, then reset while FULL.
    Send_in_EX = 1'b0; Send_in_IN = 1'b0;
    cycle();
    Ack_in = 1'b0; Send_in_EX = 1'b1; PACKET_IN_EX = 38'h15;
    cycle();
    Send_in_EX = 1'b0;
    cycle();
    check("full_send_out", 64'(Send_out),   64'(1));
    check("full_pkt",      64'(PACKET_OUT), 64'(38'h15));
    Send_in_EX = 1'b1; Send_in_IN = 1'b1;
    async_reset();
    Send_in_EX = 1'b0; Send_in_IN = 1'b0;

    // Credit cap: 32 admissions fill the ring, the 33rd waits for a RETIRE.
    Ack_in = 1'b1; Send_in_EX = 1'b1;
    for (int i = 0; i < RING_CAP; i++) begin
      PACKET_IN_EX = PKT_W'(i + 100);
      cycle();
    end
    check("cap_occ", 64'(OCC), 64'(RING_CAP));
    PACKET_IN_EX = 38'h33;
    cycle();
    check("cap_stall",    64'(lg_ex),    64'(0));
    check("cap_throttle", 64'(THROTTLE), 64'(1));
    RETIRE = 1'b1;
    cycle();
    check("cap_no_bypass", 64'(lg_ex), 64'(0));
    RETIRE = 1'b0;
    cycle();
    check("cap_regrant",     64'(lg_ex), 64'(1));
    check("cap_occ_refill",  64'(OCC),   64'(RING_CAP));
    Send_in_EX = 1'b0;
    async_reset();

    // Admission and retirement in the same cycle at OCC=5.
    Ack_in = 1'b1; Send_in_EX = 1'b1;
    for (int i = 0; i < 5; i++) begin
      PACKET_IN_EX = rand_pkt();
      cycle();
    end
    check("sim_occ5", 64'(OCC), 64'(5));
    RETIRE = 1'b1; PACKET_IN_EX = rand_pkt();
    cycle();
    check("sim_grant", 64'(lg_ex), 64'(1));
    check("sim_occ",   64'(OCC),   64'(5));
    RETIRE = 1'b0; Send_in_EX = 1'b0;

    // Random traffic: first phase fills towards the cap, second drains and underflows.
    for (int i = 0; i < 400; i++) begin
      if (lg_ex || !Send_in_EX) begin
        Send_in_EX   = ($urandom_range(0, 3) != 0);
        PACKET_IN_EX = rand_pkt();
      end
      if (lg_in || !Send_in_IN) begin
        Send_in_IN   = ($urandom_range(0, 2) == 0);
        PACKET_IN_IN = rand_pkt();
      end
      Ack_in = ($urandom_range(0, 3) != 0);
      RETIRE = (i < 200) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddp_entry_arbiter.md
Name: ddp_entry_arbiter

Overview:
- Clocked scheduler at the entry of the DDP ring, ahead of the M stage.
- Shares the single M-stage input between two requesters: external packets and internal (recirculated, B-stage) packets.
- Internal packets have priority so the ring never deadlocks. A burst limit prevents starvation of external traffic.
- A ring-occupancy credit counter throttles external admission so the ring can never be overfilled.

Parameters:
- PKT_W, 38, packet width; equals `M_PACKET_SIZE.
- OCC_W, 6, occupancy counter width.
- RING_CAP, 32, maximum packets admitted into the ring and not yet retired; must be < 2**OCC_W.
- BURST_MAX, 4, maximum consecutive internal grants while an eligible external request waits; range 1..15.

Ports:
- CP  in  1  clock, rising edge.
- MR  in  1  reset, asynchronous, active-high.
- Send_in_EX  in  1  external request; PACKET_IN_EX is stable while high.
- PACKET_IN_EX  in  PKT_W  external packet.
- Ack_out_EX  out  1  external accepted this cycle.
- Send_in_IN  in  1  internal request from the B stage.
- PACKET_IN_IN  in  PKT_W  internal packet.
- Ack_out_IN  out  1  internal accepted this cycle.
- Send_out  out  1  output register valid.
- PACKET_OUT  out  PKT_W  packet to the M stage.
- Ack_in  in  1  M stage consumed PACKET_OUT at this edge.
- RETIRE  in  1  one-cycle pulse: one packet left the ring (external exit or absorbed by join).
- OCC  out  OCC_W  current ring occupancy.
- THROTTLE  out  1  external request pending but blocked by credits.
- ERR  out  1  sticky: RETIRE seen while OCC==0.

Behaviour:
- Reset: on MR high, asynchronously clear the following and hold them while MR is high:
  - Send_out=0, PACKET_OUT=0, OCC=0, ERR=0, burst counter=0, state=EMPTY.
  - Ack_out_EX and Ack_out_IN are forced to 0.
- Reset mid-operation: any packet held in the output register is dropped; no Ack is issued.
- Transfer rule: a transfer occurs at a CP edge when Send and Ack are both high in the preceding cycle.
  - Ack_out_* are combinational and valid within the grant cycle.
  - A requester may change its packet only after an Ack edge.
- FSM: states EMPTY and FULL. Send_out is 1 exactly in FULL.
  - Define room = (state==EMPTY) or (state==FULL and Ack_in).
  - EMPTY→FULL: on a grant.
  - FULL→FULL: on Ack_in with a grant in the same cycle (back-to-back; throughput 1 packet/cycle).
  - FULL→EMPTY: on Ack_in with no grant.
  - FULL with Ack_in=0: hold; PACKET_OUT stays stable.
- Eligibility: ex_ok = Send_in_EX and OCC<RING_CAP. in_ok = Send_in_IN.
- Grant (only when room):
  - External wins if ex_ok and (not in_ok or burst==BURST_MAX).
  - Otherwise internal wins if in_ok.
  - Otherwise no grant.
  - Exactly one Ack_out may be high per cycle.
- Burst counter:
  - +1 on an internal grant while ex_ok.
  - Cleared on an external grant, or in any cycle with ex_ok=0.
  - Never exceeds BURST_MAX.
- Latency: packet appears on PACKET_OUT with Send_out=1 one CP after its grant.
- OCC update:
  - +1 on an external grant; −1 on RETIRE; both in the same cycle → unchanged.
  - RETIRE at OCC==0 → OCC stays 0 and ERR is set (sticky until MR).
  - OCC never exceeds RING_CAP, because external grants are inhibited at the cap.
  - RETIRE in the same cycle as the cap is reached frees the credit the following cycle; there is no same-cycle bypass.
- THROTTLE = Send_in_EX and OCC>=RING_CAP (combinational).
- Internal packets never consume credit.

Optional Feature:
- Macro: DDP_ARB_STATS_EN.
- Defined:
  - Adds output ports GNT_CNT_EX[15:0] and GNT_CNT_IN[15:0].
  - Each is a saturating count of grants per source, cleared by MR.
  - Adds STALL_CNT[15:0], a saturating count of cycles with THROTTLE=1.
- Undefined: these ports and registers do not exist; arbitration behaviour is identical in both builds.

Decomposition:
- macro.vh gains:
  - `ARB_OCC_W, `ARB_RING_CAP, `ARB_BURST_MAX defaults.
  - Reuse of `M_PACKET_SIZE for PKT_W.
  - State encodings `ARB_EMPTY=1'b0 and `ARB_FULL=1'b1.
- One sub-module: ddp_arb_credit. It holds the OCC counter, the ERR flag and the THROTTLE logic; inputs are grant_ex and RETIRE.
- The arbiter core, FSM and output register stay in ddp_entry_arbiter.

Test Plan:
- Reset mid-FULL: MR pulse while Send_out=1 with PACKET_OUT=38'h15 → Send_out, OCC, ERR go to 0 immediately; no Ack on either side.
- Back-to-back: Send_in_EX held with 3 packets, Ack_in tied 1 → Ack_out_EX on 3 consecutive cycles; PACKET_OUT shows the 3 packets in order 1 cycle later; OCC reaches 3.
- Starvation guard, BURST_MAX=4: both sources requesting continuously, Ack_in=1 → grant sequence IN,IN,IN,IN,EX repeating.
- Credit cap, RING_CAP=32: admit 32 external packets with no RETIRE → 33rd request stalls and THROTTLE=1. One RETIRE pulse → external grant on the next cycle; OCC=32.
- Simultaneous events: external grant with RETIRE in the same cycle at OCC=5 → OCC stays 5.
- ERR: RETIRE at OCC=0 → ERR=1 and stays 1; OCC remains 0.
